// File: rtl/alu_16.sv
// alu_16 -- 16-bit integer ALU for the RISC integer data path.
// Thirteen operations on R (register-file A port) and S (B/immediate mux).
// The result and the N/Z/C status flags are registered once per clock.
// Optional feature macro: ALU_OVF_EN adds a registered signed-overflow flag V.
// There is no enable and no handshake: a new operation is accepted every cycle.
`timescale 1ns/1ps

module alu_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] R,
    input  logic [15:0] S,
    input  logic [3:0]  Alu_OP,
    output logic [15:0] Y,
    output logic        N,
    output logic        Z,
    output logic        C
`ifdef ALU_OVF_EN
    ,
    output logic        V
`endif
);

    localparam logic [3:0] OP_PASS_S = 4'b0000;
    localparam logic [3:0] OP_PASS_R = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_INC    = 4'b0100;
    localparam logic [3:0] OP_DEC    = 4'b0101;
    localparam logic [3:0] OP_SHL    = 4'b0110;
    localparam logic [3:0] OP_SHR    = 4'b0111;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;
    localparam logic [3:0] OP_XOR    = 4'b1010;
    localparam logic [3:0] OP_NOT    = 4'b1011;
    localparam logic [3:0] OP_NEG    = 4'b1100;

    // Next {carry, result}.
    // Operands are zero-extended to 17 bits so that bit 16 carries the
    // carry-out on additions and the borrow on subtractions.
    logic [16:0] w_cy;
    logic [15:0] w_y;
    logic        w_n;
    logic        w_z;

    logic [16:0] w_r_ext;
    logic [16:0] w_s_ext;

    assign w_r_ext = {1'b0, R};
    assign w_s_ext = {1'b0, S};

    // Opcode decode: select the next 17-bit {c,y} for the current operation.
    always_comb begin
        w_cy = {1'b0, S};
        case (Alu_OP)
            OP_PASS_S: w_cy = {1'b0, S};
            OP_PASS_R: w_cy = {1'b0, R};
            OP_ADD:    w_cy = w_r_ext + w_s_ext;
            OP_SUB:    w_cy = w_r_ext - w_s_ext;
            OP_INC:    w_cy = w_s_ext + 17'd1;
            OP_DEC:    w_cy = w_s_ext - 17'd1;
            OP_SHL:    w_cy = {S[15], S[14:0], 1'b0};
            OP_SHR:    w_cy = {S[0], 1'b0, S[15:1]};
            OP_AND:    w_cy = {1'b0, R & S};
            OP_OR:     w_cy = {1'b0, R | S};
            OP_XOR:    w_cy = {1'b0, R ^ S};
            OP_NOT:    w_cy = {1'b0, ~S};
            OP_NEG:    w_cy = 17'd0 - w_s_ext;
            default:   w_cy = {1'b0, S};
        endcase
    end

    assign w_y = w_cy[15:0];
    assign w_n = w_y[15];
    assign w_z = (w_y == 16'h0000);

    // Result and status flags register together every clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Y <= 16'h0000;
            N <= 1'b0;
            Z <= 1'b0;
            C <= 1'b0;
        end else begin
            Y <= w_y;
            N <= w_n;
            Z <= w_z;
            C <= w_cy[16];
        end
    end

`ifdef ALU_OVF_EN
    // Signed overflow for the arithmetic ops; logic, shift and pass ops clear it.
    logic w_v;

    always_comb begin
        w_v = 1'b0;
        case (Alu_OP)
            OP_ADD:  w_v = (R[15] == S[15]) && (w_y[15] != R[15]);
            OP_SUB:  w_v = (R[15] != S[15]) && (w_y[15] != R[15]);
            OP_INC:  w_v = (S == 16'h7FFF);
            OP_DEC:  w_v = (S == 16'h8000);
            OP_NEG:  w_v = (S == 16'h8000);
            default: w_v = 1'b0;
        endcase
    end

    // Overflow flag registers alongside the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            V <= 1'b0;
        end else begin
            V <= w_v;
        end
    end
`endif

endmodule

// File: tb/tb_alu_16.sv
// Directed testbench for alu_16: hand-computed vectors, immediate assertions.
`timescale 1ns/1ps

module tb_alu_16;

    logic        clk;
    logic        reset;
    logic [15:0] R;
    logic [15:0] S;
    logic [3:0]  Alu_OP;
    logic [15:0] Y;
    logic        N;
    logic        Z;
    logic        C;
`ifdef ALU_OVF_EN
    logic        V;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    alu_16 dut (
        .clk    (clk),
        .reset  (reset),
        .R      (R),
        .S      (S),
        .Alu_OP (Alu_OP),
        .Y      (Y),
        .N      (N),
        .Z      (Z),
        .C      (C)
`ifdef ALU_OVF_EN
        ,
        .V      (V)
`endif
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check all registered outputs; expected overflow only checked when present.
    task automatic check_all(input string tag, input logic [15:0] ey, input logic en,
                             input logic ez, input logic ec, input logic ev);
        chk16({tag, ".Y"}, Y, ey);
        chk1({tag, ".N"}, N, en);
        chk1({tag, ".Z"}, Z, ez);
        chk1({tag, ".C"}, C, ec);
`ifdef ALU_OVF_EN
        chk1({tag, ".V"}, V, ev);
`else
        if (ev === 1'bx) $display("note: ev is x in %s", tag);
`endif
    endtask

    // Drive one operation at the falling edge, sample 1 ns after the rising edge.
    task automatic apply(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
        @(negedge clk);
        Alu_OP = op;
        R      = r;
        S      = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        R      = 16'h0000;
        S      = 16'h0000;
        Alu_OP = 4'b0000;

        // Reset state.
        #3;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Arithmetic.
        apply(4'b0010, 16'h0003, 16'h0005); check_all("add_3_5",       16'h0008, 0, 0, 0, 0);
        apply(4'b0010, 16'hFFFF, 16'h0001); check_all("add_ffff_1",    16'h0000, 0, 1, 1, 0);
        apply(4'b0010, 16'h7FFF, 16'h0001); check_all("add_7fff_1",    16'h8000, 1, 0, 0, 1);
        apply(4'b0011, 16'h0005, 16'h0001); check_all("sub_5_1",       16'h0004, 0, 0, 0, 0);
        apply(4'b0011, 16'h0001, 16'h0002); check_all("sub_1_2",       16'hFFFF, 1, 0, 1, 0);
        apply(4'b0011, 16'h8000, 16'h0001); check_all("sub_8000_1",    16'h7FFF, 0, 0, 0, 1);
        apply(4'b0100, 16'h0000, 16'hFFFF); check_all("inc_ffff",      16'h0000, 0, 1, 1, 0);
        apply(4'b0100, 16'h0000, 16'h0001); check_all("inc_1",         16'h0002, 0, 0, 0, 0);
        apply(4'b0100, 16'h0000, 16'h7FFF); check_all("inc_7fff",      16'h8000, 1, 0, 0, 1);
        apply(4'b0101, 16'h0000, 16'h0000); check_all("dec_0",         16'hFFFF, 1, 0, 1, 0);
        apply(4'b0101, 16'h0000, 16'h8000); check_all("dec_8000",      16'h7FFF, 0, 0, 0, 1);
        apply(4'b1100, 16'h0000, 16'h0003); check_all("neg_3",         16'hFFFD, 1, 0, 1, 0);
        apply(4'b1100, 16'h0000, 16'h0000); check_all("neg_0",         16'h0000, 0, 1, 0, 0);
        apply(4'b1100, 16'h0000, 16'h8000); check_all("neg_8000",      16'h8000, 1, 0, 1, 1);

        // Shifts.
        apply(4'b0110, 16'h0000, 16'h8001); check_all("shl_8001",      16'h0002, 0, 0, 1, 0);
        apply(4'b0110, 16'h0000, 16'h7FFF); check_all("shl_7fff",      16'hFFFE, 1, 0, 0, 0);
        apply(4'b0111, 16'h0000, 16'h0003); check_all("shr_3",         16'h0001, 0, 0, 1, 0);
        apply(4'b0111, 16'h0000, 16'h8000); check_all("shr_8000",      16'h4000, 0, 0, 0, 0);

        // Logic and pass ops (previous op left C=0; set C=1 first to prove it clears).
        apply(4'b0100, 16'h0000, 16'hFFFF); check_all("inc_ffff_b",    16'h0000, 0, 1, 1, 0);
        apply(4'b1000, 16'hF0F0, 16'hFF00); check_all("and",           16'hF000, 1, 0, 0, 0);
        apply(4'b1001, 16'h0F00, 16'h00F0); check_all("or",            16'h0FF0, 0, 0, 0, 0);
        apply(4'b1010, 16'hAAAA, 16'hFFFF); check_all("xor",           16'h5555, 0, 0, 0, 0);
        apply(4'b1011, 16'h0000, 16'h0009); check_all("not_9",         16'hFFF6, 1, 0, 0, 0);
        apply(4'b0001, 16'hABCD, 16'h0000); check_all("pass_r",        16'hABCD, 1, 0, 0, 0);
        apply(4'b0000, 16'hABCD, 16'h0000); check_all("pass_s_0",      16'h0000, 0, 1, 0, 0);
        apply(4'b1101, 16'h1111, 16'hFFFE); check_all("op_d",          16'hFFFE, 1, 0, 0, 0);
        apply(4'b1110, 16'h2222, 16'h0001); check_all("op_e",          16'h0001, 0, 0, 0, 0);
        apply(4'b1111, 16'h3333, 16'h0000); check_all("op_f",          16'h0000, 0, 1, 0, 0);

        // Asynchronous reset mid-stream: leaves Y=1234, then reset away from any edge.
        apply(4'b0000, 16'h0000, 16'h1234); check_all("pass_1234",     16'h1234, 0, 0, 0, 0);
        apply(4'b0010, 16'hFFFF, 16'h0001); check_all("add_carry_pre", 16'h0000, 0, 1, 1, 0);
        apply(4'b0000, 16'h0000, 16'h1234); check_all("pass_1234_b",   16'h1234, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset",  16'h0000, 0, 0, 0, 0);
        // Held in reset across a clock edge with a carry-producing op applied.
        Alu_OP = 4'b0010;
        R      = 16'hFFFF;
        S      = 16'h0001;
        @(posedge clk);
        #1;
        check_all("reset_held",   16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_release", 16'h0000, 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
